fb_region_capture: RTL and testbench

//  Reads a WIDTHxHEIGHT rectangle of the 1-bit VGA frame buffer at (base_x,base_y) and writes it

---
 rtl/fb_region_capture_pkg.sv | 20 ++
 rtl/fb_region_capture_raster_counter.sv | 38 +++
 rtl/fb_region_capture.sv | 145 ++++++++++++++
 tb/tb_fb_region_capture.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_region_capture_pkg.sv
// Shared picture-format constants and capture FSM states.
// Picture RAM pixels: black, white, or transparent for clipped area.
package fb_region_capture_pkg;

  localparam logic [1:0] PIC_BLACK = 2'd0;
  localparam logic [1:0] PIC_WHITE = 2'd1;
  localparam logic [1:0] PIC_ALPHA = 2'd2;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_COMPLETE
  } state_t;

endpackage

// File: rtl/fb_region_capture_raster_counter.sv
// Column/row raster walker over a WIDTH x HEIGHT region.
// Shared with the picture renderer.
module raster_counter #(
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int WIDTH_B  = 5,
  parameter int HEIGHT_B = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                step,
  output logic [WIDTH_B-1:0]  col,
  output logic [HEIGHT_B-1:0] row,
  output logic                last
);

  logic col_end;

  assign col_end = (col == WIDTH_B'(WIDTH - 1));
  assign last    = col_end
                 && (row == HEIGHT_B'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col_end) begin
        col <= '0;
        row <= row + HEIGHT_B'(1);
      end else begin
        col <= col + WIDTH_B'(1);
      end
    end
  end

endmodule

// File: rtl/fb_region_capture.sv
// Copies a frame-buffer rectangle into a 2-bit picture RAM;
// off-screen pixels become transparent and are never read.
module fb_region_capture
  import fb_region_capture_pkg::*;
#(
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int WIDTH_B    = 5,
  parameter int HEIGHT_B   = 5,
  parameter int PIC_LENGTH = 10,
  parameter int RD_LAT     = 1,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_capture,
  input  logic [8:0]            base_x,
  input  logic [7:0]            base_y,
  output logic [8:0]            fb_x,
  output logic [7:0]            fb_y,
  output logic                  fb_rd_en,
  input  logic                  fb_rdata,
  output logic [PIC_LENGTH-1:0] pic_address,
  output logic [1:0]            pic_wdata,
  output logic                  pic_wren,
  output logic                  busy,
  output logic                  capture_complete
);

  state_t state, state_n;

  logic [8:0]          bx;
  logic [7:0]          by;
  logic [1:0]          wait_cnt;
  logic [WIDTH_B-1:0]  col;
  logic [HEIGHT_B-1:0] row;
  logic                last;
  logic                clr;
  logic                step;
  logic [9:0]          sum_x;
  logic [8:0]          sum_y;
  logic                clip;
  logic                accept;

  raster_counter #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .WIDTH_B  (WIDTH_B),
    .HEIGHT_B (HEIGHT_B)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .step  (step),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  assign accept = (state == S_IDLE) && start_capture;

  // Sums are one bit wider so a wrap past 511/255 still clips.
  assign sum_x = {1'b0, bx} + 10'(col);
  assign sum_y = {1'b0, by} + 9'(row);
  assign clip  = (sum_x >= 10'(SCREEN_W))
              || (sum_y >= 9'(SCREEN_H));
  assign fb_x  = sum_x[8:0];
  assign fb_y  = sum_y[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      bx       <= '0;
      by       <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        bx <= base_x;
        by <= base_y;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_n          = state;
    clr              = 1'b0;
    step             = 1'b0;
    fb_rd_en         = 1'b0;
    pic_wren         = 1'b0;
    pic_address      = '0;
    pic_wdata        = PIC_BLACK;
    busy             = 1'b0;
    capture_complete = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_capture) begin
          clr     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy     = 1'b1;
        fb_rd_en = ~clip;
        state_n  = (RD_LAT == 1) ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == 2'(RD_LAT - 2)) begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        busy        = 1'b1;
        pic_wren    = 1'b1;
        pic_address = PIC_LENGTH'(row) * PIC_LENGTH'(WIDTH)
                    + PIC_LENGTH'(col);
        if (clip) begin
          pic_wdata = PIC_ALPHA;
        end else begin
          pic_wdata = fb_rdata ? PIC_WHITE : PIC_BLACK;
        end
        if (last) begin
          state_n = S_COMPLETE;
        end else begin
          step    = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_COMPLETE: begin
        busy             = 1'b1;
        capture_complete = 1'b1;
        state_n          = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_region_capture.sv
// Bench for fb_region_capture: three instances (latency 1,
// latency 3, 3x2 region) checked against a write scoreboard.
module tb_fb_region_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start [3];
  logic [8:0] base_x [3];
  logic [7:0] base_y [3];
  logic [8:0] fb_x [3];
  logic [7:0] fb_y [3];
  logic       fb_rd_en [3];
  logic       fb_rdata [3];
  logic [9:0] pic_address [3];
  logic [1:0] pic_wdata [3];
  logic       pic_wren [3];
  logic       busy [3];
  logic       capture_complete [3];

  logic [2:0] rd_pipe [3];
  logic [2:0] d_pipe [3];

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t       q[$];
  logic [1:0] seen [1024];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  fb_region_capture u_l1 (
    .clk(clk), .reset(reset), .start_capture(start[0]),
    .base_x(base_x[0]), .base_y(base_y[0]),
    .fb_x(fb_x[0]), .fb_y(fb_y[0]), .fb_rd_en(fb_rd_en[0]),
    .fb_rdata(fb_rdata[0]), .pic_address(pic_address[0]),
    .pic_wdata(pic_wdata[0]), .pic_wren(pic_wren[0]),
    .busy(busy[0]), .capture_complete(capture_complete[0])
  );

  fb_region_capture #(.RD_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .start_capture(start[1]),
    .base_x(base_x[1]), .base_y(base_y[1]),
    .fb_x(fb_x[1]), .fb_y(fb_y[1]), .fb_rd_en(fb_rd_en[1]),
    .fb_rdata(fb_rdata[1]), .pic_address(pic_address[1]),
    .pic_wdata(pic_wdata[1]), .pic_wren(pic_wren[1]),
    .busy(busy[1]), .capture_complete(capture_complete[1])
  );

  fb_region_capture #(
    .WIDTH(3), .HEIGHT(2), .WIDTH_B(2), .HEIGHT_B(1)
  ) u_small (
    .clk(clk), .reset(reset), .start_capture(start[2]),
    .base_x(base_x[2]), .base_y(base_y[2]),
    .fb_x(fb_x[2]), .fb_y(fb_y[2]), .fb_rd_en(fb_rd_en[2]),
    .fb_rdata(fb_rdata[2]), .pic_address(pic_address[2]),
    .pic_wdata(pic_wdata[2]), .pic_wren(pic_wren[2]),
    .busy(busy[2]), .capture_complete(capture_complete[2])
  );

  // Frame buffer: pixel (x^y)&1, valid only RD_LAT clocks after the read.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rd_pipe[i] <= {rd_pipe[i][1:0], fb_rd_en[i]};
      d_pipe[i]  <= {d_pipe[i][1:0], fb_x[i][0] ^ fb_y[i][0]};
    end
  end

  always_comb begin
    fb_rdata[0] = rd_pipe[0][0] ? d_pipe[0][0] : 1'bx;
    fb_rdata[1] = rd_pipe[1][2] ? d_pipe[1][2] : 1'bx;
    fb_rdata[2] = rd_pipe[2][0] ? d_pipe[2][0] : 1'bx;
  end

  task automatic push_exp(input int w, input int h,
                          input int bx, input int by,
                          output int n_rd);
    exp_t e;
    int   sx;
    int   sy;
    bit   cl;
    n_rd = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        sx = bx + c;
        sy = by + r;
        cl = (sx >= 320) || (sy >= 240);
        e.addr = r * w + c;
        e.data = cl ? 2 : ((sx ^ sy) & 1);
        if (!cl) n_rd++;
        q.push_back(e);
      end
    end
  endtask

  task automatic run_capture(
    input  int i, input int bx, input int by,
    input  int w, input int h, input int lat,
    input  int re1, input int re2, input int rst_at,
    output int writes, output int done_cnt,
    output int done_at, output int rd_cnt,
    output int late);
    int   n;
    int   limit;
    int   last_rd;
    bit   aborted;
    exp_t e;
    writes   = 0;
    done_cnt = 0;
    done_at  = 0;
    rd_cnt   = 0;
    late     = 0;
    last_rd  = -100;
    aborted  = 1'b0;
    limit    = w * h * (lat + 1) + 1 + 8;
    base_x[i] = 9'(bx);
    base_y[i] = 8'(by);
    start[i]  = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    start[i]  = 1'b0;
    base_x[i] = 9'd50;
    base_y[i] = 8'd60;
    while (n <= limit) begin
      if (aborted) begin
        if (pic_wren[i] || capture_complete[i] || fb_rd_en[i])
          late++;
      end else begin
        if (fb_rd_en[i]) begin
          rd_cnt++;
          last_rd = n;
        end
        if (pic_wren[i]) begin
          writes++;
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL extra_write inst%0d: addr %0d, none expected",
                     i, pic_address[i]);
          end else begin
            e = q.pop_front();
            if ({pic_address[i], pic_wdata[i]} !==
                {10'(e.addr), 2'(e.data)}) begin
              fails++;
              $display("FAIL write inst%0d: got addr %0d data %0d, need addr %0d data %0d",
                       i, pic_address[i], pic_wdata[i], e.addr, e.data);
            end
            seen[pic_address[i]] = pic_wdata[i];
            if (e.data != 2) begin
              tests++;
              if (n - last_rd != lat) begin
                fails++;
                $display("FAIL rd_to_wr inst%0d: got %0d clocks, need %0d",
                         i, n - last_rd, lat);
              end
            end
          end
        end
        if (capture_complete[i]) begin
          done_cnt++;
          if (done_at == 0) done_at = n;
        end
      end
      start[i] = (n == re1) || (n == re2);
      if (!aborted && rst_at > 0 && pic_wren[i] && writes == rst_at) begin
        reset = 1'b0;
        @(posedge clk);
        n++;
        #1;
        reset = 1'b1;
        aborted = 1'b1;
        tests++;
        if ({fb_rd_en[i], pic_wren[i], busy[i], capture_complete[i],
             pic_wdata[i], fb_x[i], fb_y[i], pic_address[i]} !== '0) begin
          fails++;
          $display("FAIL mid_reset_outputs inst%0d: got wren %b busy %b addr %0d fb_x %0d, need all 0",
                   i, pic_wren[i], busy[i], pic_address[i], fb_x[i]);
        end
      end
      @(posedge clk);
      n++;
      #1;
    end
    start[i] = 1'b0;
  endtask

  task automatic check_run(input string nm, input int i,
                           input int writes, input int need_w,
                           input int done_cnt, input int done_at,
                           input int need_at, input int rd_cnt,
                           input int need_rd);
    tests++;
    if (writes != need_w) begin
      fails++;
      $display("FAIL %s_writes: got %0d, need %0d", nm, writes, need_w);
    end
    tests++;
    if (done_cnt != 1 || done_at != need_at) begin
      fails++;
      $display("FAIL %s_complete: got %0d pulses at clock %0d, need 1 at %0d",
               nm, done_cnt, done_at, need_at);
    end
    tests++;
    if (rd_cnt != need_rd) begin
      fails++;
      $display("FAIL %s_reads: got %0d, need %0d", nm, rd_cnt, need_rd);
    end
    tests++;
    if (q.size() != 0 || busy[i] !== 1'b0) begin
      fails++;
      $display("FAIL %s_leftover: got %0d pending busy %b, need 0 pending busy 0",
               nm, q.size(), busy[i]);
    end
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({fb_rd_en[i], pic_wren[i], busy[i], capture_complete[i],
           pic_wdata[i], fb_x[i], fb_y[i], pic_address[i]} !== '0) begin
        fails++;
        $display("FAIL reset_outputs inst%0d: got wren %b busy %b fb_x %0d addr %0d, need all 0",
                 i, pic_wren[i], busy[i], fb_x[i], pic_address[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lat1();
    int nrd, w, d, da, rd, lt;
    push_exp(28, 28, 10, 20, nrd);
    run_capture(0, 10, 20, 28, 28, 1, 0, 0, 0, w, d, da, rd, lt);
    check_run("lat1", 0, w, 784, d, da, 1569, rd, nrd);
  endtask

  task automatic test_lat3();
    int nrd, w, d, da, rd, lt;
    push_exp(28, 28, 10, 20, nrd);
    run_capture(1, 10, 20, 28, 28, 3, 0, 0, 0, w, d, da, rd, lt);
    check_run("lat3", 1, w, 784, d, da, 3137, rd, nrd);
  endtask

  task automatic test_clip();
    int nrd, w, d, da, rd, lt;
    push_exp(28, 28, 300, 230, nrd);
    run_capture(0, 300, 230, 28, 28, 1, 0, 0, 0, w, d, da, rd, lt);
    check_run("clip", 0, w, 784, d, da, 1569, rd, 200);
    tests++;
    if (seen[20] !== 2'b10 || seen[0] !== 2'((300 ^ 230) & 1)) begin
      fails++;
      $display("FAIL clip_pixels: got addr20=%0d addr0=%0d, need 2 and %0d",
               seen[20], seen[0], (300 ^ 230) & 1);
    end
  endtask

  task automatic test_busy_restart();
    int nrd, w, d, da, rd, lt;
    push_exp(28, 28, 10, 20, nrd);
    run_capture(0, 10, 20, 28, 28, 1, 5, 400, 0, w, d, da, rd, lt);
    check_run("restart", 0, w, 784, d, da, 1569, rd, nrd);
  endtask

  task automatic test_mid_reset();
    int nrd, w, d, da, rd, lt;
    push_exp(28, 28, 10, 20, nrd);
    run_capture(0, 10, 20, 28, 28, 1, 0, 0, 100, w, d, da, rd, lt);
    tests++;
    if (w != 100 || d != 0 || lt != 0) begin
      fails++;
      $display("FAIL mid_reset_abort: got %0d writes %0d done %0d late, need 100 0 0",
               w, d, lt);
    end
    q.delete();
    push_exp(28, 28, 10, 20, nrd);
    run_capture(0, 10, 20, 28, 28, 1, 0, 0, 0, w, d, da, rd, lt);
    check_run("after_reset", 0, w, 784, d, da, 1569, rd, nrd);
  endtask

  task automatic test_small();
    int nrd, w, d, da, rd, lt;
    push_exp(3, 2, 7, 9, nrd);
    run_capture(2, 7, 9, 3, 2, 1, 13, 0, 0, w, d, da, rd, lt);
    check_run("small", 2, w, 6, d, da, 13, rd, nrd);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i]  = 1'b0;
      base_x[i] = '0;
      base_y[i] = '0;
    end
    test_reset();
    test_lat1();
    test_lat3();
    test_clip();
    test_busy_restart();
    test_mid_reset();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
